tlul_sram_responder: RTL and testbench
======================================

Name: tlul_sram_responder

Overview:
- TL-UL device-side responder backed by a small internal word memory.
- Accepts Get, PutFullData and PutPartialData on the A channel and returns AccessAckData or AccessAck on the D channel.
- Serves as a synthesizable instruction/data memory endpoint for ibex_tlul host ports in benches and small SoC configurations.
- Replaces hand-driven D-channel stimulus with a protocol-correct, back-pressurable responder.

Parameters:
- Depth, 16: number of 32-bit words; power of two, at least 2.
- BaseAddr, 32'h0000_0000: byte address of word 0; must be aligned to Depth*4.
- Outstanding, 2: response FIFO depth, i.e. the maximum number of accepted requests not yet taken on the D channel; at least 1.
- ErrOnPartialFull, 1'b0: when 1, PutFullData with a_mask != 4'hF returns d_error=1.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset.
- tl_i  input  tlul_pkg::tl_h2d_t  A-channel request and d_ready from the host.
- tl_o  output  tlul_pkg::tl_d2h_t  D-channel response and a_ready to the host.
- busy_o  output  1  high while the response FIFO is non-empty.

Behaviour:
- Clocking and reset: one clock clk_i; reset rst_i is asynchronous and active-high.
- Reset values:
  - tl_o.a_ready=0 while rst_i is high; 1 in the first cycle after release.
  - tl_o.d_valid=0, busy_o=0.
  - All other tl_o fields are 0, except d_user=TL_D_USER_DEFAULT.
  - FIFO pointers and count are 0; every memory word is 32'h0.
- Acceptance:
  - A request is taken on a rising edge with a_valid && a_ready.
  - a_ready = !rst_i && (count != Outstanding). There is no pass-through: a_ready stays 0 when full, even if a pop occurs in the same cycle.
- Decode, on the accepted beat:
  - idx = (a_address - BaseAddr) >> 2.
  - err is set when any of these holds: address is outside [BaseAddr, BaseAddr+Depth*4); a_address[1:0] != 0; a_size != 2; opcode is not in {Get=4, PutFullData=0, PutPartialData=1}; ErrOnPartialFull && PutFullData && a_mask != 4'hF.
- Write:
  - Applies only to a non-error Put.
  - mem[idx] byte lane b takes a_data[8b+7:8b] when a_mask[b] is set, on the same edge as acceptance.
  - An error Put never modifies memory.
- Read:
  - For a Get, rdata = mem[idx] is sampled at acceptance, before any write on that edge.
  - A Get in the cycle after a Put to the same word returns the new value.
  - An error Get returns rdata=32'hFFFF_FFFF.
- Response push: {opcode, size, source, data, err} is pushed into the FIFO on acceptance.
  - d_opcode = AccessAckData (1) for Get, otherwise AccessAck (0). This holds for error responses too, keyed on the received opcode.
  - An unsupported opcode returns AccessAck with d_error=1.
  - d_size and d_source echo the request; d_param=0; d_sink=0; d_user=TL_D_USER_DEFAULT.
  - d_data=0 for AccessAck.
- Latency: d_valid rises in the cycle after acceptance (registered FIFO output), so the minimum request-to-response latency is 1 cycle.
- Response pop:
  - The head is popped on d_valid && d_ready.
  - While d_ready=0, the head holds all fields stable.
  - Responses are returned strictly in acceptance order.
- Push and pop in the same edge leave count unchanged.
- busy_o = (count != 0).
- Reset mid-operation: the FIFO is flushed and memory is cleared. No response is produced for requests accepted before reset.

Decomposition:
- New package tlul_sram_responder_pkg holds the rsp_entry_t struct (opcode, size, source, data, err) and an AccessAck/AccessAckData selection function. All TL-UL types and defaults come from tlul_pkg.
- One sub-module, tlul_rsp_fifo: a synchronous FIFO of rsp_entry_t, parameterized by Outstanding, with full, empty and count outputs and an asynchronous active-high reset.
- Memory and decode stay in the top module.

Test Plan:
- Reset: hold rst_i=1 for 3 cycles -> a_ready=0, d_valid=0, busy_o=0. Release -> a_ready=1 on the next cycle.
- Write then read back:
  - Stimulus: PutFullData addr 0x8, data 32'hDEADBEEF, mask F, source 3; then Get addr 0x8, source 5.
  - Response 1: d_opcode=0, d_source=3, d_error=0, 1 cycle after acceptance.
  - Response 2: d_opcode=1, d_data=32'hDEADBEEF, d_source=5.
- Partial write: on word 0x8, PutPartialData data 32'h1122_3344, mask 4'b0011 -> a subsequent Get returns 32'hDEAD_3344.
- Errors, each with memory unchanged:
  - Get addr BaseAddr+Depth*4 (0x40) -> d_error=1, d_data=32'hFFFF_FFFF, opcode 1.
  - Get addr 0x2 -> d_error=1.
  - Opcode 7 -> AccessAck with d_error=1.
- Backpressure:
  - Hold d_ready=0 and issue 3 Gets back-to-back -> 2 accepted, then a_ready=0. The head stays stable for 5 cycles.
  - Raise d_ready -> responses drain in order, a_ready returns after the first pop, and the third Get completes.
- Reset mid-op: with 2 responses queued, pulse rst_i asynchronously mid-cycle -> d_valid drops immediately, busy_o=0, and a Get of 0x8 after release returns 0.

Source files
------------

// File: rtl/tlul_pkg.sv
// TL-UL bus types, opcodes and default user fields shared by hosts and devices.
package tlul_pkg;

    localparam int unsigned TL_AW  = 32;
    localparam int unsigned TL_DW  = 32;
    localparam int unsigned TL_AIW = 8;
    localparam int unsigned TL_DIW = 1;
    localparam int unsigned TL_SZW = 2;
    localparam int unsigned TL_DBW = TL_DW / 8;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [3:0] instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    localparam tl_d_user_t TL_D_USER_DEFAULT = '{rsp_intg: 7'h0, data_intg: 7'h0};

    typedef struct packed {
        logic                a_valid;
        logic [2:0]          a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        tl_a_user_t          a_user;
        logic                d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                d_valid;
        logic [2:0]          d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic [TL_DW-1:0]    d_data;
        tl_d_user_t          d_user;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_sram_responder_pkg.sv
// Response FIFO payload and D-channel opcode selection for the SRAM responder.
package tlul_sram_responder_pkg;

    import tlul_pkg::*;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [TL_SZW-1:0] size;
        logic [TL_AIW-1:0] source;
        logic [TL_DW-1:0]  data;
        logic              err;
    } rsp_entry_t;

    // Keyed on the received opcode, so error and unsupported requests still get a matching ack type.
    function automatic logic [2:0] ack_opcode(input logic [2:0] a_opcode);
        return (a_opcode == 3'(Get)) ? 3'(AccessAckData) : 3'(AccessAck);
    endfunction

endpackage

// File: rtl/tlul_rsp_fifo.sv
// Synchronous response FIFO; full/empty are registered alongside the occupancy count.
module tlul_rsp_fifo
    import tlul_sram_responder_pkg::*;
#(
    parameter int unsigned Outstanding = 2,
    localparam int unsigned CntW = $clog2(Outstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push,
    input  rsp_entry_t      wdata,
    input  logic            pop,
    output rsp_entry_t      rdata,
    output logic            full,
    output logic            empty,
    output logic [CntW-1:0] count
);

    localparam int unsigned PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;

    rsp_entry_t      entries [Outstanding];
    logic [PtrW-1:0] wptr;
    logic [PtrW-1:0] rptr;
    logic [CntW-1:0] count_next;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Outstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CntW'(1);
            2'b01:   count_next = count - CntW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            count <= count_next;
            full  <= (count_next == CntW'(Outstanding));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
            for (int unsigned i = 0; i < Outstanding; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (push) begin
                entries[wptr] <= wdata;
                wptr          <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
        end
    end

    assign rdata = entries[rptr];

endmodule

// File: rtl/tlul_sram_responder.sv
// TL-UL device responder backed by a word memory; responses queue in a back-pressurable FIFO.
module tlul_sram_responder
    import tlul_pkg::*;
    import tlul_sram_responder_pkg::*;
#(
    parameter int unsigned Depth            = 16,
    parameter logic [31:0] BaseAddr         = 32'h0000_0000,
    parameter int unsigned Outstanding      = 2,
    parameter bit          ErrOnPartialFull = 1'b0
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  tl_h2d_t tl_i,
    output tl_d2h_t tl_o,
    output logic    busy_o
);

    localparam int unsigned IdxW      = $clog2(Depth);
    localparam int unsigned CntW      = $clog2(Outstanding + 1);
    localparam logic [31:0] SpanBytes = 32'(Depth * 4);

    logic [TL_DW-1:0] mem [Depth];

    logic             a_ready;
    logic             accept;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CntW-1:0]  count;
    logic [31:0]      offset;
    logic [IdxW-1:0]  idx;
    logic             in_range;
    logic             is_get;
    logic             is_put;
    logic             err;
    logic [TL_DW-1:0] rdata;
    rsp_entry_t       push_entry;
    rsp_entry_t       head;
    logic             unused_bits;

    assign a_ready = !rst_i && !full;
    assign accept  = tl_i.a_valid && a_ready;
    assign pop     = !empty && tl_i.d_ready;
    assign busy_o  = (count != '0);

    // Request decode; the read samples memory before any write on the accepting edge.
    always_comb begin
        offset   = tl_i.a_address - BaseAddr;
        idx      = offset[IdxW+1:2];
        in_range = (offset < SpanBytes);
        is_get   = (tl_i.a_opcode == 3'(Get));
        is_put   = (tl_i.a_opcode == 3'(PutFullData)) || (tl_i.a_opcode == 3'(PutPartialData));
        err      = !in_range
                || (tl_i.a_address[1:0] != 2'b00)
                || (tl_i.a_size != TL_SZW'(2))
                || !(is_get || is_put)
                || (ErrOnPartialFull && (tl_i.a_opcode == 3'(PutFullData)) && (tl_i.a_mask != 4'hF));
        rdata = '0;
        if (is_get) begin
            rdata = err ? '1 : mem[idx];
        end
        push_entry = '{
            opcode: ack_opcode(tl_i.a_opcode),
            size:   tl_i.a_size,
            source: tl_i.a_source,
            data:   rdata,
            err:    err
        };
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (accept && is_put && !err) begin
            for (int unsigned b = 0; b < TL_DBW; b++) begin
                if (tl_i.a_mask[b]) begin
                    mem[idx][8*b +: 8] <= tl_i.a_data[8*b +: 8];
                end
            end
        end
    end

    tlul_rsp_fifo #(
        .Outstanding (Outstanding)
    ) u_rsp_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (accept),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = !empty;
        tl_o.d_opcode = head.opcode;
        tl_o.d_size   = head.size;
        tl_o.d_source = head.source;
        tl_o.d_data   = head.data;
        tl_o.d_error  = head.err;
        tl_o.d_user   = TL_D_USER_DEFAULT;
        tl_o.a_ready  = a_ready;
    end

    assign unused_bits = ^{offset[31:IdxW+2], offset[1:0], tl_i.a_param, tl_i.a_user};

endmodule

// File: tb/tb_tlul_sram_responder.sv
// Randomized and directed bench for tlul_sram_responder against a queue/array reference model.
module tb_tlul_sram_responder;

    import tlul_pkg::*;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned OUTST  = 2;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam bit          ERR_PF = 1'b0;
    localparam int unsigned NRAND  = 200;

    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [7:0]  src;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    tl_h2d_t tl_i;
    tl_d2h_t tl_o;
    logic    busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_mem [DEPTH];
    exp_t        exp_q [$];

    always #5 clk = ~clk;

    tlul_sram_responder #(
        .Depth            (DEPTH),
        .BaseAddr         (BASE),
        .Outstanding      (OUTST),
        .ErrOnPartialFull (ERR_PF)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .tl_i   (tl_i),
        .tl_o   (tl_o),
        .busy_o (busy)
    );

    function automatic exp_t snap();
        return '{op: tl_o.d_opcode, size: tl_o.d_size, src: tl_o.d_source,
                 data: tl_o.d_data, err: tl_o.d_error};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        exp_q.delete();
    endtask

    // Reference: what the spec says one accepted request returns, and its memory effect.
    task automatic model_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] mask, input logic [1:0] size, input logic [7:0] src,
                             output exp_t e);
        bit         inr;
        bit         err;
        logic [3:0] w;
        inr = ({32'h0, addr} >= {32'h0, BASE}) && ({32'h0, addr} < {32'h0, BASE} + 64'(DEPTH * 4));
        w   = inr ? 4'((addr - BASE) >> 2) : 4'h0;
        err = !inr || (addr[1:0] != 2'b00) || (size != 2'd2)
           || !(op == 3'd0 || op == 3'd1 || op == 3'd4)
           || (ERR_PF && op == 3'd0 && mask != 4'hF);
        e.op   = (op == 3'd4) ? 3'd1 : 3'd0;
        e.size = size;
        e.src  = src;
        e.err  = err;
        e.data = 32'h0;
        if (op == 3'd4) begin
            e.data = err ? 32'hFFFF_FFFF : model_mem[w];
        end else if (!err) begin
            for (int b = 0; b < 4; b++)
                if (mask[b]) model_mem[w][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] mask, input logic [1:0] size, input logic [7:0] src);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_param   = 3'h0;
        tl_i.a_size    = size;
        tl_i.a_source  = src;
        tl_i.a_address = addr;
        tl_i.a_mask    = mask;
        tl_i.a_data    = data;
        tl_i.a_user    = '0;
    endtask

    // One request with d_ready high; called and returns on a falling edge.
    task automatic xact(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [1:0] size, input logic [7:0] src,
                        output exp_t got, output exp_t e, output int lat);
        int waits = 0;
        drive_req(op, addr, data, mask, size, src);
        while (tl_o.a_ready !== 1'b1 && waits < 20) begin @(negedge clk); waits++; end
        if (tl_o.a_ready !== 1'b1) begin
            $display("FAIL xact_accept: a_ready=%b after %0d cycles, required 1", tl_o.a_ready, waits);
            n_cmp++; n_bad++;
        end
        model_req(op, addr, data, mask, size, src, e);
        @(posedge clk);
        @(negedge clk);
        tl_i.a_valid = 1'b0;
        lat = 1;
        while (tl_o.d_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        if (tl_o.d_valid !== 1'b1) begin
            $display("FAIL xact_resp: d_valid=%b after %0d cycles, required 1", tl_o.d_valid, lat);
            n_cmp++; n_bad++;
        end
        got = snap();
    endtask

    task automatic test_reset();
        tl_i = '0;
        tl_i.d_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (tl_o.a_ready !== 1'b0) begin n_bad++; $display("FAIL rst_a_ready: got %b required 0", tl_o.a_ready); end
        n_cmp++; if (tl_o.d_valid !== 1'b0) begin n_bad++; $display("FAIL rst_d_valid: got %b required 0", tl_o.d_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_cmp++; if (tl_o.d_user !== TL_D_USER_DEFAULT || tl_o.d_data !== 32'h0 || tl_o.d_error !== 1'b0)
            begin n_bad++; $display("FAIL rst_fields: user=%h data=%h err=%b required %h/0/0", tl_o.d_user, tl_o.d_data, tl_o.d_error, TL_D_USER_DEFAULT); end
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        n_cmp++; if (tl_o.a_ready !== 1'b1) begin n_bad++; $display("FAIL rel_a_ready: got %b required 1", tl_o.a_ready); end
    endtask

    task automatic test_write_read();
        exp_t got, e;
        int   lat;
        xact(3'd0, 32'h8, 32'hDEAD_BEEF, 4'hF, 2'd2, 8'd3, got, e, lat);
        n_cmp++; if (got !== e) begin n_bad++; $display("FAIL wr_rsp: got %h required %h", got, e); end
        n_cmp++; if (got.op !== 3'd0 || got.src !== 8'd3 || got.err !== 1'b0)
            begin n_bad++; $display("FAIL wr_fields: op=%0d src=%0d err=%b required 0/3/0", got.op, got.src, got.err); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL wr_latency: got %0d required 1", lat); end
        xact(3'd4, 32'h8, 32'h0, 4'hF, 2'd2, 8'd5, got, e, lat);
        n_cmp++; if (got !== e) begin n_bad++; $display("FAIL rd_rsp: got %h required %h", got, e); end
        n_cmp++; if (got.op !== 3'd1 || got.data !== 32'hDEAD_BEEF || got.src !== 8'd5)
            begin n_bad++; $display("FAIL rd_fields: op=%0d data=%h src=%0d required 1/deadbeef/5", got.op, got.data, got.src); end
        n_cmp++; if (tl_o.d_param !== 3'h0 || tl_o.d_sink !== 1'b0)
            begin n_bad++; $display("FAIL rd_param_sink: param=%0d sink=%0d required 0/0", tl_o.d_param, tl_o.d_sink); end
    endtask

    task automatic test_partial();
        exp_t got, e;
        int   lat;
        xact(3'd1, 32'h8, 32'h1122_3344, 4'b0011, 2'd2, 8'd1, got, e, lat);
        n_cmp++; if (got !== e) begin n_bad++; $display("FAIL pp_rsp: got %h required %h", got, e); end
        xact(3'd4, 32'h8, 32'h0, 4'hF, 2'd2, 8'd2, got, e, lat);
        n_cmp++; if (got.data !== 32'hDEAD_3344 || got !== e)
            begin n_bad++; $display("FAIL pp_readback: got %h required %h (data dead3344)", got, e); end
    endtask

    task automatic test_errors();
        exp_t got, e;
        int   lat;
        xact(3'd4, 32'h40, 32'h0, 4'hF, 2'd2, 8'd7, got, e, lat);
        n_cmp++; if (got.err !== 1'b1 || got.data !== 32'hFFFF_FFFF || got.op !== 3'd1 || got !== e)
            begin n_bad++; $display("FAIL err_oor_get: got %h required %h", got, e); end
        xact(3'd4, 32'h2, 32'h0, 4'hF, 2'd2, 8'd8, got, e, lat);
        n_cmp++; if (got.err !== 1'b1 || got !== e) begin n_bad++; $display("FAIL err_misalign: got %h required %h", got, e); end
        xact(3'd7, 32'h8, 32'h5555_5555, 4'hF, 2'd2, 8'd9, got, e, lat);
        n_cmp++; if (got.err !== 1'b1 || got.op !== 3'd0 || got.data !== 32'h0 || got !== e)
            begin n_bad++; $display("FAIL err_badop: got %h required %h", got, e); end
        xact(3'd0, 32'h8, 32'h0BAD_0BAD, 4'hF, 2'd1, 8'd10, got, e, lat);
        n_cmp++; if (got.err !== 1'b1 || got !== e) begin n_bad++; $display("FAIL err_size: got %h required %h", got, e); end
        xact(3'd0, 32'h48, 32'h0BAD_0BAD, 4'hF, 2'd2, 8'd11, got, e, lat);
        n_cmp++; if (got !== e) begin n_bad++; $display("FAIL err_oor_put: got %h required %h", got, e); end
        xact(3'd4, 32'h8, 32'h0, 4'hF, 2'd2, 8'd12, got, e, lat);
        n_cmp++; if (got.data !== 32'hDEAD_3344 || got !== e)
            begin n_bad++; $display("FAIL err_mem_kept: got %h required %h", got, e); end
        xact(3'd0, 32'hC, 32'hA5A5_5A5A, 4'h5, 2'd2, 8'd13, got, e, lat);
        n_cmp++; if (got.err !== 1'b0 || got !== e) begin n_bad++; $display("FAIL pf_partial_mask: got %h required %h", got, e); end
        xact(3'd4, 32'hC, 32'h0, 4'hF, 2'd2, 8'd14, got, e, lat);
        n_cmp++; if (got !== e) begin n_bad++; $display("FAIL pf_readback: got %h required %h", got, e); end
    endtask

    task automatic test_backpressure();
        exp_t got, e, e1, e2, e3, held;
        int   lat;
        for (int w = 1; w <= 3; w++) begin
            xact(3'd0, 32'(w * 4), $urandom, 4'hF, 2'd2, 8'(w), got, e, lat);
            n_cmp++; if (got !== e) begin n_bad++; $display("FAIL bp_fill%0d: got %h required %h", w, got, e); end
        end
        @(negedge clk);
        tl_i.d_ready = 1'b0;
        drive_req(3'd4, 32'h4, 32'h0, 4'hF, 2'd2, 8'd21);
        model_req(3'd4, 32'h4, 32'h0, 4'hF, 2'd2, 8'd21, e1);
        @(posedge clk); @(negedge clk);
        drive_req(3'd4, 32'h8, 32'h0, 4'hF, 2'd2, 8'd22);
        model_req(3'd4, 32'h8, 32'h0, 4'hF, 2'd2, 8'd22, e2);
        @(posedge clk); @(negedge clk);
        drive_req(3'd4, 32'hC, 32'h0, 4'hF, 2'd2, 8'd23);
        n_cmp++; if (tl_o.a_ready !== 1'b0 || busy !== 1'b1)
            begin n_bad++; $display("FAIL bp_full: a_ready=%b busy=%b required 0/1", tl_o.a_ready, busy); end
        held = snap();
        n_cmp++; if (held !== e1 || tl_o.d_valid !== 1'b1) begin n_bad++; $display("FAIL bp_head: got %h required %h", held, e1); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (snap() !== held || tl_o.a_ready !== 1'b0)
                begin n_bad++; $display("FAIL bp_hold%0d: head %h a_ready %b required %h/0", c, snap(), tl_o.a_ready, held); end
        end
        tl_i.d_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        n_cmp++; if (tl_o.a_ready !== 1'b1 || snap() !== e2)
            begin n_bad++; $display("FAIL bp_drain1: a_ready=%b head=%h required 1/%h", tl_o.a_ready, snap(), e2); end
        model_req(3'd4, 32'hC, 32'h0, 4'hF, 2'd2, 8'd23, e3);
        @(posedge clk); @(negedge clk);
        tl_i.a_valid = 1'b0;
        n_cmp++; if (snap() !== e3 || tl_o.d_valid !== 1'b1)
            begin n_bad++; $display("FAIL bp_third: head=%h valid=%b required %h/1", snap(), tl_o.d_valid, e3); end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || tl_o.d_valid !== 1'b0)
            begin n_bad++; $display("FAIL bp_empty: busy=%b valid=%b required 0/0", busy, tl_o.d_valid); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] bad_ops [5] = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        int         rcv = 0;
        @(negedge clk);
        fork
            begin : driver
                logic [2:0]  op;
                logic [31:0] addr;
                logic [3:0]  mask;
                logic [1:0]  size;
                exp_t        e;
                int unsigned r;
                for (int k = 0; k < NRAND; k++) begin
                    int waits = 0;
                    r = $urandom_range(0, 9);
                    op = (r < 4 || r == 9) ? 3'd4 : (r < 6) ? 3'd0 : (r < 8) ? 3'd1 : bad_ops[$urandom_range(0, 4)];
                    r = $urandom_range(0, 9);
                    addr = (r == 0) ? 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3))
                         : (r == 1) ? 32'($urandom_range(16, 255) * 4)
                         : (r < 6)  ? 32'($urandom_range(0, 3) * 4)
                         :            32'($urandom_range(0, 15) * 4);
                    size = ($urandom_range(0, 15) == 0) ? 2'd1 : 2'd2;
                    mask = 4'($urandom);
                    drive_req(op, addr, $urandom, mask, size, 8'($urandom));
                    forever begin
                        n_cmp++;
                        if (tl_o.a_ready !== (exp_q.size() != OUTST) || busy !== (exp_q.size() != 0)) begin
                            n_bad++;
                            $display("FAIL b2b_flow: a_ready=%b busy=%b with %0d queued", tl_o.a_ready, busy, exp_q.size());
                        end
                        if (tl_o.a_ready === 1'b1 || waits >= 100) break;
                        @(posedge clk); @(negedge clk);
                        waits++;
                    end
                    if (tl_o.a_ready !== 1'b1) begin
                        n_cmp++; n_bad++;
                        $display("FAIL b2b_accept: request %0d never accepted", k);
                        break;
                    end
                    model_req(tl_i.a_opcode, tl_i.a_address, tl_i.a_data, tl_i.a_mask, tl_i.a_size, tl_i.a_source, e);
                    @(posedge clk);
                    exp_q.push_back(e);
                    @(negedge clk);
                    tl_i.a_valid = 1'b0;
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                end
                tl_i.a_valid = 1'b0;
            end
            begin : monitor
                int cyc = 0;
                while (rcv < NRAND && cyc < NRAND * 40) begin
                    bit popping;
                    tl_i.d_ready = ($urandom_range(0, 3) != 0);
                    popping = (tl_o.d_valid === 1'b1) && tl_i.d_ready;
                    if (popping) begin
                        n_cmp++;
                        if (exp_q.size() == 0) begin
                            n_bad++; $display("FAIL b2b_spurious: response %h with none outstanding", snap());
                        end else if (snap() !== exp_q[0] || tl_o.d_param !== 3'h0 || tl_o.d_user !== TL_D_USER_DEFAULT) begin
                            n_bad++; $display("FAIL b2b_rsp%0d: got %h required %h", rcv, snap(), exp_q[0]);
                        end
                    end
                    @(posedge clk);
                    if (popping) begin
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        rcv++;
                    end
                    @(negedge clk);
                    cyc++;
                end
                n_cmp++;
                if (rcv != NRAND) begin n_bad++; $display("FAIL b2b_count: received %0d required %0d", rcv, NRAND); end
                tl_i.d_ready = 1'b1;
            end
        join
    endtask

    task automatic test_reset_midop();
        exp_t got, e;
        int   lat;
        @(negedge clk);
        tl_i.d_ready = 1'b0;
        drive_req(3'd4, 32'h8, 32'h0, 4'hF, 2'd2, 8'd31);
        @(posedge clk); @(negedge clk);
        drive_req(3'd4, 32'h4, 32'h0, 4'hF, 2'd2, 8'd32);
        @(posedge clk); @(negedge clk);
        tl_i.a_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1 || tl_o.d_valid !== 1'b1)
            begin n_bad++; $display("FAIL mid_queued: busy=%b valid=%b required 1/1", busy, tl_o.d_valid); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (tl_o.d_valid !== 1'b0 || busy !== 1'b0 || tl_o.a_ready !== 1'b0)
            begin n_bad++; $display("FAIL mid_flush: valid=%b busy=%b a_ready=%b required 0/0/0", tl_o.d_valid, busy, tl_o.a_ready); end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        tl_i.d_ready = 1'b1;
        xact(3'd4, 32'h8, 32'h0, 4'hF, 2'd2, 8'd33, got, e, lat);
        n_cmp++; if (got.data !== 32'h0 || got !== e) begin n_bad++; $display("FAIL mid_cleared: got %h required %h", got, e); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_no_stale: busy=%b required 0", busy); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_partial();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
